// File: rtl/sbit_frame_serializer_pkg.sv
// Shared constants and word-source encodings for the S-bit frame serializer.
package sbit_frame_serializer_pkg;

  localparam int MXIO      = 8;
  localparam int WORD_SIZE = 8;
  localparam int MXSBITS   = MXIO * WORD_SIZE;
  localparam int FCNT_W    = 16;

  // Word source selected at each load edge
  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_WALK = 2'd1,
    MODE_ONES = 2'd2,
    MODE_FCNT = 2'd3
  } mode_e;

  // Bits of the frame counter the pattern generator actually needs:
  // enough to index the walking one and to fill one lane byte.
  function automatic int pat_bits(input int mxsbits, input int word_size);
    int walk_w;
    walk_w = $clog2(mxsbits);
    return (walk_w > word_size) ? walk_w : word_size;
  endfunction

endpackage

// File: rtl/sbit_pattern_gen.sv
// Combinational selection of the next word to transmit (data, test patterns, mask).
module sbit_pattern_gen
  import sbit_frame_serializer_pkg::*;
#(
  parameter int MXIO      = sbit_frame_serializer_pkg::MXIO,
  parameter int WORD_SIZE = sbit_frame_serializer_pkg::WORD_SIZE,
  parameter int MXSBITS   = MXIO * WORD_SIZE,
  parameter int PAT_W     = pat_bits(MXSBITS, WORD_SIZE)
) (
  input  logic [1:0]         mode,
  input  logic               mask,
  input  logic [MXSBITS-1:0] sbits,
  input  logic [PAT_W-1:0]   frame_cnt,
  output logic [MXSBITS-1:0] word
);

  localparam int WALK_W = $clog2(MXSBITS);

  // Mask wins over every source; the counter patterns use the pre-increment count.
  always_comb begin
    word = '0;
    if (!mask) begin
      case (mode_e'(mode))
        MODE_PASS: word = sbits;
        MODE_WALK: word[frame_cnt[WALK_W-1:0]] = 1'b1;
        MODE_ONES: word = '1;
        MODE_FCNT: word = {MXIO{frame_cnt[WORD_SIZE-1:0]}};
        default:   word = '0;
      endcase
    end
  end

endmodule

// File: rtl/sbit_frame_serializer.sv
// Serialises one S-bit word per frame MSB-first onto MXIO SDR lanes with a SOF marker.
// A slip pulse stalls every piece of state for one clock so the receiver's
// SOF search can be exercised against a shifted frame boundary.
module sbit_frame_serializer
  import sbit_frame_serializer_pkg::*;
#(
  parameter int MXIO      = sbit_frame_serializer_pkg::MXIO,
  parameter int WORD_SIZE = sbit_frame_serializer_pkg::WORD_SIZE,
  parameter int MXSBITS   = MXIO * WORD_SIZE,
  parameter int FCNT_W    = sbit_frame_serializer_pkg::FCNT_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [MXSBITS-1:0] sbits_i,
  output logic               load_o,
  input  logic               mask_i,
  input  logic [1:0]         mode_i,
  input  logic               slip_i,
  output logic [MXIO-1:0]    d_o,
  output logic               sof_o,
  output logic [FCNT_W-1:0]  frame_cnt_o
);

  localparam int PHASE_W = $clog2(WORD_SIZE);
  localparam int PAT_W   = pat_bits(MXSBITS, WORD_SIZE);
  localparam logic [PHASE_W-1:0] P_LAST  = PHASE_W'(WORD_SIZE - 1);
  // Reset one phase before the load phase so the first SOF lands two cycles after release
  localparam logic [PHASE_W-1:0] P_RESET = PHASE_W'(WORD_SIZE - 2);

  logic [PHASE_W-1:0]                p;
  logic [MXIO-1:0][WORD_SIZE-1:0]    sr;
  logic [MXSBITS-1:0]                word;

  sbit_pattern_gen #(
    .MXIO      (MXIO),
    .WORD_SIZE (WORD_SIZE),
    .MXSBITS   (MXSBITS),
    .PAT_W     (PAT_W)
  ) u_pat (
    .mode      (mode_i),
    .mask      (mask_i),
    .sbits     (sbits_i),
    .frame_cnt (frame_cnt_o[PAT_W-1:0]),
    .word      (word)
  );

  assign load_o = (p == P_LAST);

  // Each lane's MSB goes straight out of its shift-register flop
  for (genvar i = 0; i < MXIO; i++) begin : g_lane
    assign d_o[i] = sr[i][WORD_SIZE-1];
  end

  // Phase counter, lane shift registers, SOF and frame counter; slip freezes all of them
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      p           <= P_RESET;
      sr          <= '0;
      sof_o       <= 1'b0;
      frame_cnt_o <= '0;
    end else if (!slip_i) begin
      if (p == P_LAST) begin
        p           <= '0;
        sr          <= word;
        sof_o       <= 1'b1;
        frame_cnt_o <= frame_cnt_o + 1'b1;
      end else begin
        p     <= p + 1'b1;
        sof_o <= 1'b0;
        for (int i = 0; i < MXIO; i++) begin
          sr[i] <= {sr[i][WORD_SIZE-2:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_sbit_frame_serializer.sv
// Bench for sbit_frame_serializer: frame table, hand-written slip/reset sequences,
// and random stimulus against a queue-of-expected-outputs reference model.
module tb_sbit_frame_serializer;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] sbits_i;
  logic        load_o;
  logic        mask_i;
  logic [1:0]  mode_i;
  logic        slip_i;
  logic [7:0]  d_o;
  logic        sof_o;
  logic [15:0] frame_cnt_o;

  sbit_frame_serializer dut (
    .clock       (clock),
    .reset       (reset),
    .sbits_i     (sbits_i),
    .load_o      (load_o),
    .mask_i      (mask_i),
    .mode_i      (mode_i),
    .slip_i      (slip_i),
    .d_o         (d_o),
    .sof_o       (sof_o),
    .frame_cnt_o (frame_cnt_o)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The serializer is viewed as a stream of per-cycle output symbols: a load
  // pushes a whole frame's worth of symbols, each unstalled edge consumes one.
  typedef struct packed { logic [7:0] d; logic sof; } sym_t;
  sym_t        q[$];
  sym_t        cur;
  logic [15:0] m_fcnt;

  function automatic logic [63:0] ref_word(input logic [1:0] mode, input logic mask,
                                           input logic [63:0] sb, input logic [15:0] fc);
    logic [63:0] w;
    if (mask) return 64'h0;
    case (mode)
      2'd0:    w = sb;
      2'd1:    w = 64'h1 << (fc % 64);
      2'd2:    w = {64{1'b1}};
      default: w = {8{fc[7:0]}};
    endcase
    return w;
  endfunction

  task automatic model_reset();
    q.delete();
    cur = '0;
    q.push_back(sym_t'(0));   // the one idle cycle before the first load
    m_fcnt = 16'd0;
  endtask

  task automatic model_step();
    logic [63:0] w;
    sym_t        s;
    if (slip_i) return;
    if (q.size() == 0) begin
      w = ref_word(mode_i, mask_i, sbits_i, m_fcnt);
      for (int k = 0; k < 8; k++) begin
        s.sof = (k == 0);
        for (int i = 0; i < 8; i++) s.d[i] = w[8*i + 7 - k];
        q.push_back(s);
      end
      m_fcnt = m_fcnt + 16'd1;
    end
    cur = q.pop_front();
  endtask

  task automatic check_outputs();
    chk("d_o",       {56'h0, d_o},         {56'h0, cur.d});
    chk("sof_o",     {63'h0, sof_o},       {63'h0, cur.sof});
    chk("load_o",    {63'h0, load_o},      {63'h0, (q.size() == 0)});
    chk("frame_cnt", {48'h0, frame_cnt_o}, {48'h0, m_fcnt});
  endtask

  // One clock: model consumes current inputs, DUT clocks, outputs checked mid-cycle
  task automatic step();
    model_step();
    @(posedge clock);
    @(negedge clock);
    check_outputs();
  endtask

  task automatic wait_load();
    int n = 0;
    while (!load_o && n < 20) begin step(); n++; end
    if (!load_o) chk("wait_load_timeout", 64'h0, 64'h1);
  endtask

  task automatic wait_sof();
    int n = 0;
    while (!sof_o && n < 20) begin step(); n++; end
    if (!sof_o) chk("wait_sof_timeout", 64'h0, 64'h1);
  endtask

  // Collect a frame starting at the SOF cycle; ends on the following load cycle
  task automatic recv(output logic [63:0] w);
    w = '0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step();
      for (int i = 0; i < 8; i++) w[8*i + 7 - k] = d_o[i];
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    chk("rst_d_o",   {56'h0, d_o},         64'h0);
    chk("rst_sof",   {63'h0, sof_o},       64'h0);
    chk("rst_fcnt",  {48'h0, frame_cnt_o}, 64'h0);
    chk("rst_load",  {63'h0, load_o},      64'h0);
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check_outputs();
    // first SOF in the 2nd cycle after release
    step();
    chk("rel_c1_sof",  {63'h0, sof_o},  64'h0);
    chk("rel_c1_load", {63'h0, load_o}, 64'h1);
    step();
    chk("rel_c2_sof",  {63'h0, sof_o},  64'h1);
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic        mask;
    logic [63:0] sbits;
    logic [63:0] exp;
  } vec_t;
  vec_t tbl[8];

  initial begin
    logic [63:0] got;
    int          n;

    // frames are applied in order from reset, so frame index == pre-load count
    tbl[0] = '{2'd0, 1'b0, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF};
    tbl[1] = '{2'd1, 1'b0, 64'hFFFF0000FFFF0000, 64'h0000000000000002};
    tbl[2] = '{2'd3, 1'b0, 64'h0,                64'h0202020202020202};
    tbl[3] = '{2'd2, 1'b1, 64'h5555AAAA5555AAAA, 64'h0};
    tbl[4] = '{2'd2, 1'b0, 64'h0,                64'hFFFFFFFFFFFFFFFF};
    tbl[5] = '{2'd1, 1'b0, 64'h0,                64'h0000000000000020};
    tbl[6] = '{2'd3, 1'b0, 64'h1234,             64'h0606060606060606};
    tbl[7] = '{2'd0, 1'b0, 64'hDEADBEEFCAFEF00D, 64'hDEADBEEFCAFEF00D};

    sbits_i = 64'h0123456789ABCDEF;
    mode_i  = 2'd0;
    mask_i  = 1'b0;
    slip_i  = 1'b0;
    reset   = 1'b0;
    @(negedge clock);
    // release leaves us in the first SOF cycle of frame 0
    do_reset();

    // first frame: 0x0123456789ABCDEF, lane 0 = 0xEF, lane 7 = 0x01
    recv(got);
    chk("tbl0_word", got, tbl[0].exp);
    chk("tbl0_lane0", {56'h0, got[7:0]},   64'hEF);
    chk("tbl0_lane7", {56'h0, got[63:56]}, 64'h01);

    for (int v = 1; v < 8; v++) begin
      wait_load();
      mode_i  = tbl[v].mode;
      mask_i  = tbl[v].mask;
      sbits_i = tbl[v].sbits;
      step();
      chk($sformatf("tbl%0d_sof", v), {63'h0, sof_o}, 64'h1);
      recv(got);
      chk($sformatf("tbl%0d_word", v), got, tbl[v].exp);
    end
    mask_i = 1'b0;

    // walking one across the counter wrap of bit index 63 -> 0
    mode_i = 2'd1;
    for (int f = 0; f < 70; f++) begin
      logic [15:0] fc;
      wait_load();
      fc = m_fcnt;
      step();
      recv(got);
      chk("walk_word", got, 64'h1 << (fc % 64));
    end

    // slip at phase 3: SOF spacing 9 then 8
    mode_i = 2'd2;
    wait_sof();
    step(); step(); step();
    slip_i = 1'b1;
    step();
    chk("slip3_repeat_d", {56'h0, d_o}, 64'hFF);
    slip_i = 1'b0;
    n = 4;
    do begin step(); n++; end while (!sof_o && n < 20);
    chk("slip3_spacing", 64'(n), 64'd9);
    n = 0;
    do begin step(); n++; end while (!sof_o && n < 20);
    chk("post_slip_spacing", 64'(n), 64'd8);

    // slip on the load cycle: load held, second-cycle sbits transmitted
    mode_i = 2'd0;
    wait_load();
    sbits_i = 64'h1111111111111111;
    slip_i  = 1'b1;
    step();
    chk("slip7_load_held", {63'h0, load_o}, 64'h1);
    slip_i  = 1'b0;
    sbits_i = 64'hA5C3F00F12345678;
    step();
    chk("slip7_sof", {63'h0, sof_o}, 64'h1);
    recv(got);
    chk("slip7_word", got, 64'hA5C3F00F12345678);

    // asynchronous reset at phase 4 with all-ones on the lanes
    mode_i = 2'd2;
    wait_load();
    step();
    step(); step(); step(); step();
    chk("pre_rst_d", {56'h0, d_o}, 64'hFF);
    do_reset();
    recv(got);
    chk("after_rst_word", got, {64{1'b1}});

    // randomized traffic with occasional slips and masks
    for (int c = 0; c < 4000; c++) begin
      sbits_i = {$urandom(), $urandom()};
      mode_i  = 2'($urandom_range(0, 3));
      mask_i  = ($urandom_range(0, 7) == 0);
      slip_i  = ($urandom_range(0, 11) == 0);
      step();
    end

    // long counter-pattern run with rare slips
    mask_i = 1'b0;
    mode_i = 2'd3;
    for (int c = 0; c < 6000; c++) begin
      slip_i = ($urandom_range(0, 1999) == 0);
      step();
    end
    slip_i = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sbit_frame_serializer.md
Name: sbit_frame_serializer

Overview:
- Transmit-side counterpart of the S-bit frame alignment path.
- Takes one 64-bit S-bit word per frame and serialises it MSB-first onto 8 single-data-rate lanes at one bit per clock, with a one-bit-wide start-of-frame (SOF) marker.
- Used as a VFAT3 trigger-link emulator for loopback and aligner qualification.
- Supports built-in test patterns and a bit-slip control, so the receiver's SOF search can be exercised.

Parameters:
- MXIO, 8, number of data lanes.
- WORD_SIZE, 8, bits per lane per frame (frame length in clocks).
- MXSBITS, MXIO*WORD_SIZE (64), S-bit word width.
- FCNT_W, 16, frame counter width.

Ports:
- clock  in  1  bit-rate clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- sbits_i  in  MXSBITS  S-bit word to transmit.
- load_o  out  1  high while the frame phase is WORD_SIZE-1; sbits_i is sampled at the rising edge ending a load_o cycle, unless slip_i is high.
- mask_i  in  1  forces the loaded word to zero (SOF still sent).
- mode_i  in  2  word source: 0 sbits_i, 1 walking one, 2 all ones, 3 frame-counter pattern.
- slip_i  in  1  single-cycle pulse; stalls the serializer one clock (bit slip).
- d_o  out  MXIO  serial lane outputs.
- sof_o  out  1  start-of-frame marker.
- frame_cnt_o  out  FCNT_W  number of frames loaded since reset.

Behaviour:

Reset state (asynchronous):
- Phase counter p=WORD_SIZE-2 (6). Lane shift registers sr[i]=0, sof_o=0, frame_cnt_o=0.
- load_o is a combinational decode (p==WORD_SIZE-1), so it is 0 during reset.

Each rising clock edge, with slip_i=0:
- p increments, wrapping 7->0.
- If p==7 (load edge):
  - sr[i] <= word[8i+7:8i].
  - sof_o <= 1.
  - frame_cnt_o <= frame_cnt_o+1, wrapping at 2^FCNT_W.
- Otherwise: sr[i] <= sr[i]<<1 (zero fill) and sof_o <= 0.

Lane and SOF timing:
- d_o[i] is sr[i][WORD_SIZE-1], driven straight from a flop.
- During frame phase k (cycle with p==k), lane i carries bit (7-k) of its byte.
- So S-bit 8i+7 goes first and S-bit 8i goes last, matching the receiver's MSB-first shift-in.
- sof_o is high exactly during the p==0 cycle, coincident with the MSB. SOF is therefore low for 7 consecutive cycles before every rise, as the receiver's inverted-pair guard requires.

Latency:
- sbits_i sampled at a load edge appears on d_o starting the very next cycle; the byte completes 8 cycles later.
- First SOF after reset release occurs in the 2nd cycle after release.

Word selection (mode_i and mask_i are sampled at the load edge):
- mask_i=1 -> word=0, regardless of mode.
- mode 0 -> sbits_i.
- mode 1 -> one-hot, with bit index = frame_cnt_o[5:0] (value before the increment).
- mode 2 -> all ones.
- mode 3 -> {MXIO{frame_cnt_o[7:0]}}, using the value before the increment.

Slip (slip_i=1 at an edge):
- p, sr, sof_o and frame_cnt_o all hold, so the current bit and SOF level repeat for one extra cycle. This shifts the SOF position by one clock relative to any external 40 MHz reference.
- Slip on a p==7 cycle: the load is deferred, load_o stays high one more cycle, and sbits_i is sampled at the following edge.
- Back-to-back slip cycles each add one cycle of stall.

Reset mid-frame:
- Asynchronous return to the reset state; the partial frame is dropped.

Decomposition:
- Shared package: MXIO, WORD_SIZE, MXSBITS, mode encodings (MODE_PASS=0, MODE_WALK=1, MODE_ONES=2, MODE_FCNT=3).
- Optional sub-module sbit_pattern_gen: combinational word selection from mode_i, mask_i, sbits_i and frame_cnt_o.
- Counter, shift registers and SOF stay in the top module.

Test Plan:
1. Reset release, mode 0, sbits_i=64'h0123456789ABCDEF held constant -> sof_o first high 2 cycles after release, then every 8 cycles.
   - Lane 0 shows 1,1,1,0,1,1,1,1 (0xEF MSB-first) in the 8 cycles starting at SOF.
   - Lane 7 shows 0x01 MSB-first.
   - frame_cnt_o increments once per frame.
2. Mode 1 for 70 frames -> a deserialised frame n has only bit n%64 set. The frame after frame 63 has bit 0 set again.
3. mask_i=1 with mode 2 -> all d_o are 0 while SOF continues every 8 cycles. Deassert mask_i -> the next loaded frame is all ones on every lane.
4. Pulse slip_i once at p==3 -> the current bit is repeated, the next SOF arrives 9 cycles after the previous one, and later spacing returns to 8.
   - Pulse slip_i at p==7 instead -> load_o is high 2 cycles, and sbits_i changed in the second cycle is the value transmitted.
5. Assert reset at p==4 mid-frame -> d_o and sof_o go to 0 immediately (asynchronously) and frame_cnt_o goes to 0. Restart timing after release matches scenario 1.
6. Loopback into the frame-alignment receiver with mode 3 and random slip pulses every ≥200 frames -> the receiver reasserts alignment after each slip, and the recovered words equal {8{frame count}} with no bit reordering.
